mux_sel_serializer: RTL and testbench

Sequential select sequencer and parallel-to-serial stage that drives an 8:1 mux. Accepts an 8-bit word over a valid/ready handshake, then steps the 3-bit select `{s0,s1,s2}` through all eight codes, one per accepted output beat, presenting the selected bit as a serial stream with valid/ready flow control. It sits directly upstream of the mux select inputs and consumes the mux output `y` as its serial data.

---
 rtl/mux_sel_serializer_pkg.sv | 24 ++
 rtl/mux_sel_serializer_mux_8x1.sv | 35 +++
 rtl/mux_sel_serializer.sv | 114 +++++++++++
 tb/tb_mux_sel_serializer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mux_sel_serializer_pkg.sv
// Shared definitions for the mux select sequencer / serializer.
// Contents: select and input widths, the sequencer state enum, and the
// start / end select codes for either bit order.
package mux_sel_serializer_pkg;

    localparam int SEL_W = 3;
    localparam int N_IN  = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // First select code of a word: i0 for LSB-first, i7 for MSB-first.
    function automatic logic [SEL_W-1:0] start_code(input logic msb_first);
        return msb_first ? 3'b111 : 3'b000;
    endfunction

    // Select code of the eighth (last) beat of a word.
    function automatic logic [SEL_W-1:0] end_code(input logic msb_first);
        return msb_first ? 3'b000 : 3'b111;
    endfunction

endpackage

// File: rtl/mux_sel_serializer_mux_8x1.sv
// 8:1 multiplexer.
// Ports: i0..i7 data inputs; s0 (select MSB), s1, s2 (select LSB);
//        y = i[{s0,s1,s2}].
module mux_8x1 (
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    input  logic i4,
    input  logic i5,
    input  logic i6,
    input  logic i7,
    input  logic s0,
    input  logic s1,
    input  logic s2,
    output logic y
);

    // Select one of eight inputs by the 3-bit code {s0,s1,s2}.
    always_comb begin
        y = 1'b0;
        case ({s0, s1, s2})
            3'b000:  y = i0;
            3'b001:  y = i1;
            3'b010:  y = i2;
            3'b011:  y = i3;
            3'b100:  y = i4;
            3'b101:  y = i5;
            3'b110:  y = i6;
            3'b111:  y = i7;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_sel_serializer.sv
// Select sequencer and parallel-to-serial stage driving an 8:1 mux.
// Accepts an 8-bit word (in_valid/in_ready), then walks the mux select
// {s0,s1,s2} through all eight codes, one per accepted beat, and presents
// the mux output as a serial stream (ser_valid/out_ready).
// Ports: clk, rst (sync, active-high); in_valid, in_ready, in_data[7:0];
//        s0, s1, s2 select outputs; ser_out, ser_valid, ser_last,
//        out_ready; busy (word in flight).
module mux_sel_serializer
    import mux_sel_serializer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_data,
    output logic            s0,
    output logic            s1,
    output logic            s2,
    output logic            ser_out,
    output logic            ser_valid,
    output logic            ser_last,
    input  logic            out_ready,
    output logic            busy
);

    localparam logic [SEL_W-1:0] START_SEL = start_code(MSB_FIRST);
    localparam logic [SEL_W-1:0] END_SEL   = end_code(MSB_FIRST);

    state_t            state_r;
    logic [N_IN-1:0]   hold_r;
    logic [SEL_W-1:0]  sel_r;
    logic              at_end_s;
    logic              xfer_s;

    // Handshake and status decode from the current state and select.
    always_comb begin
        at_end_s  = (sel_r == END_SEL);
        ser_valid = (state_r == SHIFT);
        busy      = (state_r == SHIFT);
        ser_last  = ser_valid && at_end_s;
        xfer_s    = ser_valid && out_ready;
        // A new word can be taken while idle, or on the cycle the last
        // beat leaves, which gives back-to-back words without a bubble.
        if (state_r == IDLE) begin
            in_ready = 1'b1;
        end else begin
            in_ready = ser_last && out_ready;
        end
    end

    assign s0 = sel_r[2];
    assign s1 = sel_r[1];
    assign s2 = sel_r[0];

    mux_8x1 u_mux (
        .i0 (hold_r[0]),
        .i1 (hold_r[1]),
        .i2 (hold_r[2]),
        .i3 (hold_r[3]),
        .i4 (hold_r[4]),
        .i5 (hold_r[5]),
        .i6 (hold_r[6]),
        .i7 (hold_r[7]),
        .s0 (s0),
        .s1 (s1),
        .s2 (s2),
        .y  (ser_out)
    );

    // Sequencer: word load, select stepping on each transfer, end detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            hold_r  <= '0;
            sel_r   <= START_SEL;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        hold_r  <= in_data;
                        sel_r   <= START_SEL;
                        state_r <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (xfer_s) begin
                        // End code is compared explicitly; the counter
                        // is never allowed to wrap on its own.
                        if (at_end_s) begin
                            sel_r <= START_SEL;
                            if (in_valid) begin
                                hold_r  <= in_data;
                                state_r <= SHIFT;
                            end else begin
                                state_r <= IDLE;
                            end
                        end else if (MSB_FIRST) begin
                            sel_r <= sel_r - 3'd1;
                        end else begin
                            sel_r <= sel_r + 3'd1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    sel_r   <= START_SEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_serializer.sv
// Self-checking bench for mux_sel_serializer. Both bit orders are
// instantiated side by side on the same stimulus. A queue-of-beats model
// predicts every output each cycle: an accepted word pushes its eight
// beats (bit value, select code, last flag); a transfer pops one.
module tb_mux_sel_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic in_ready0, s00, s10, s20, ser_out0, ser_valid0, ser_last0, busy0;
    logic in_ready1, s01, s11, s21, ser_out1, ser_valid1, ser_last1, busy1;

    always #5 clk = ~clk;

    mux_sel_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .s0(s00), .s1(s10), .s2(s20),
        .ser_out(ser_out0), .ser_valid(ser_valid0), .ser_last(ser_last0),
        .out_ready(out_ready), .busy(busy0)
    );

    mux_sel_serializer #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .s0(s01), .s1(s11), .s2(s21),
        .ser_out(ser_out1), .ser_valid(ser_valid1), .ser_last(ser_last1),
        .out_ready(out_ready), .busy(busy1)
    );

    int errors = 0;
    int checks = 0;

    // Beat entries: {last, sel[2:0], bit}. q0 is LSB-first, q1 MSB-first.
    logic [4:0] q0[$];
    logic [4:0] q1[$];
    logic [7:0] last_word = 8'h00;
    logic       accepted;
    logic       checking = 1'b0;
    int         beats_seen = 0;

    task automatic check_eq(input string tag, input logic [7:0] got,
                            input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, then
    // advance the model across the coming rising edge.
    task automatic cycle(input logic iv, input logic [7:0] d,
                         input logic ordy, input logic r);
        logic       ev, eir;
        logic [4:0] e0, e1;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        rst       = r;
        #1;
        ev  = (q0.size() != 0);
        eir = !ev || (q0.size() == 1 && ordy);
        e0  = ev ? q0[0] : {1'b0, 3'b000, last_word[0]};
        e1  = ev ? q1[0] : {1'b0, 3'b111, last_word[7]};
        if (checking) begin
            check_eq("in_ready0",  {7'd0, in_ready0},  {7'd0, eir});
            check_eq("in_ready1",  {7'd0, in_ready1},  {7'd0, eir});
            check_eq("ser_valid0", {7'd0, ser_valid0}, {7'd0, ev});
            check_eq("ser_valid1", {7'd0, ser_valid1}, {7'd0, ev});
            check_eq("busy0",      {7'd0, busy0},      {7'd0, ev});
            check_eq("busy1",      {7'd0, busy1},      {7'd0, ev});
            check_eq("sel0",  {5'd0, s00, s10, s20}, {5'd0, e0[3:1]});
            check_eq("sel1",  {5'd0, s01, s11, s21}, {5'd0, e1[3:1]});
            check_eq("ser_out0",  {7'd0, ser_out0},  {7'd0, e0[0]});
            check_eq("ser_out1",  {7'd0, ser_out1},  {7'd0, e1[0]});
            check_eq("ser_last0", {7'd0, ser_last0}, {7'd0, e0[4]});
            check_eq("ser_last1", {7'd0, ser_last1}, {7'd0, e1[4]});
        end
        accepted = 1'b0;
        if (r) begin
            q0.delete();
            q1.delete();
            last_word = 8'h00;
        end else begin
            if (ev && ordy) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
                beats_seen++;
            end
            if (iv && eir) begin
                accepted  = 1'b1;
                last_word = d;
                for (int k = 0; k < 8; k++) begin
                    logic [2:0] c0, c1;
                    c0 = 3'(k);
                    c1 = 3'(7 - k);
                    q0.push_back({(k == 7), c0, d[c0]});
                    q1.push_back({(k == 7), c1, d[c1]});
                end
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        logic       iv;
        logic [7:0] wd;
        logic       pend;

        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1; rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        checking = 1'b1;
        // Reset state (both orders), then idle with no request.
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // A5 then 81, each drained with out_ready held high.
        cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        idle_cycles(9);
        cycle(1'b1, 8'h81, 1'b1, 1'b0);
        idle_cycles(9);

        // 3C with a 3-cycle stall on beat 4.
        cycle(1'b1, 8'h3C, 1'b1, 1'b0);
        idle_cycles(3);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        idle_cycles(6);

        // FF then 00 back-to-back with in_valid continuous.
        beats_seen = 0;
        cycle(1'b1, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'h00, 1'b1, 1'b0);
        idle_cycles(8);
        check_eq("b2b_beats", 8'(beats_seen), 8'd16);

        // Reset during beat 5 of F0.
        cycle(1'b1, 8'hF0, 1'b1, 1'b0);
        idle_cycles(4);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        idle_cycles(3);

        // 55 offered during beat 3 of 96, then withdrawn: ignored.
        beats_seen = 0;
        cycle(1'b1, 8'h96, 1'b1, 1'b0);
        idle_cycles(2);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        idle_cycles(7);
        check_eq("ignored_beats", 8'(beats_seen), 8'd8);

        // Randomized traffic: words held until accepted, random stalls,
        // rare resets.
        pend = 1'b0;
        wd   = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            logic r, ordy;
            if (!pend) begin
                iv = ($urandom_range(0, 3) != 0);
                wd = 8'($urandom);
            end else begin
                iv = 1'b1;
            end
            ordy = ($urandom_range(0, 3) != 0);
            r    = ($urandom_range(0, 199) == 0);
            cycle(iv, wd, ordy, r);
            pend = iv && !accepted && !r;
        end
        idle_cycles(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
